// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter: packet-granular arbiter sharing the PCIe AXI-stream TX port
// between the completion engine (r0), the DMA write engine (r1) and the core's
// configuration-TLP requests. Only the grant decision is registered; the data
// path is a combinational mux under the registered grant.
// Optional feature macro: PCIE_TX_ARB_STATS_EN adds per-requester packet counters.
module pcie_tx_arbiter #(
    parameter int unsigned MIN_BUF_AV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        user_lnk_up,
    input  logic [5:0]  tx_buf_av,
    input  logic        tx_cfg_req,
    output logic        tx_cfg_gnt,
    input  logic [31:0] r0_tdata,
    input  logic [3:0]  r0_tkeep,
    input  logic [3:0]  r0_tuser,
    input  logic        r0_tlast,
    input  logic        r0_tvalid,
    output logic        r0_tready,
    input  logic [31:0] r1_tdata,
    input  logic [3:0]  r1_tkeep,
    input  logic [3:0]  r1_tuser,
    input  logic        r1_tlast,
    input  logic        r1_tvalid,
    output logic        r1_tready,
    output logic [31:0] s_axis_tx_tdata,
    output logic [3:0]  s_axis_tx_tkeep,
    output logic [3:0]  s_axis_tx_tuser,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    output logic [1:0]  grant,
    output logic        busy
`ifdef PCIE_TX_ARB_STATS_EN
    ,
    output logic [15:0] r0_pkt_count,
    output logic [15:0] r1_pkt_count
`endif
);

    localparam int unsigned BUF_W = 6;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        CFG  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_served;
    logic   last_served_nxt;
    logic   eligible;
    logic   done0;
    logic   done1;

    // A new requester packet may start only with the link up and enough core buffers.
    assign eligible = user_lnk_up && (tx_buf_av >= BUF_W'(MIN_BUF_AV));

    // Final beat of the owning requester's packet is accepted by the bridge.
    assign done0 = (state == GNT0) && r0_tvalid && s_axis_tx_tready && r0_tlast;
    assign done1 = (state == GNT1) && r1_tvalid && s_axis_tx_tready && r1_tlast;

    // Grant state and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
        end
    end

    // Next-state: CFG first, then single requester, ties go to the one not served last.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        case (state)
            IDLE: begin
                if (tx_cfg_req) begin
                    state_nxt = CFG;
                end else if (eligible) begin
                    case ({r1_tvalid, r0_tvalid})
                        2'b01:   state_nxt = GNT0;
                        2'b10:   state_nxt = GNT1;
                        2'b11:   state_nxt = last_served ? GNT0 : GNT1;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            GNT0: begin
                if (done0) begin
                    state_nxt       = IDLE;
                    last_served_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (done1) begin
                    state_nxt       = IDLE;
                    last_served_nxt = 1'b1;
                end
            end
            CFG: begin
                if (!tx_cfg_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stream mux and status decode driven by the registered grant state.
    always_comb begin
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tuser  = '0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tvalid = 1'b0;
        r0_tready        = 1'b0;
        r1_tready        = 1'b0;
        grant            = 2'b00;
        tx_cfg_gnt       = 1'b0;
        busy             = (state != IDLE);
        case (state)
            GNT0: begin
                s_axis_tx_tdata  = r0_tdata;
                s_axis_tx_tkeep  = r0_tkeep;
                s_axis_tx_tuser  = r0_tuser;
                s_axis_tx_tlast  = r0_tlast;
                s_axis_tx_tvalid = r0_tvalid;
                r0_tready        = s_axis_tx_tready;
                grant            = 2'b01;
            end
            GNT1: begin
                s_axis_tx_tdata  = r1_tdata;
                s_axis_tx_tkeep  = r1_tkeep;
                s_axis_tx_tuser  = r1_tuser;
                s_axis_tx_tlast  = r1_tlast;
                s_axis_tx_tvalid = r1_tvalid;
                r1_tready        = s_axis_tx_tready;
                grant            = 2'b10;
            end
            CFG: begin
                tx_cfg_gnt = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef PCIE_TX_ARB_STATS_EN
    // Completed-packet counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_pkt_count <= '0;
            r1_pkt_count <= '0;
        end else begin
            if (done0) begin
                r0_pkt_count <= r0_pkt_count + CNT_W'(1);
            end
            if (done1) begin
                r1_pkt_count <= r1_pkt_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-granular arbiter that shares the single 32-bit PCIe AXI-stream transmit port (`s_axis_tx_*`) between two requesters: requester 0, the completion engine, and requester 1, the DMA write engine. It also grants the hard core's configuration-TLP requests (`tx_cfg_req`/`tx_cfg_gnt`). The block sits between the user-side TLP generators and the PCIe AXI bridge, in the `user_clk_out` domain. The data path is combinational pass-through; only the grant decision is registered.

## Interface
Parameters:
- `MIN_BUF_AV`, default 2: minimum `tx_buf_av` required before a new requester packet is granted.

Ports:
- `clk` in 1: user clock, the bridge's `user_clk_out`.
- `rst` in 1: reset, the bridge's `user_reset_out`. Synchronous, active-high.
- `user_lnk_up` in 1: link up. No new grants are issued while it is low.
- `tx_buf_av` in 6: transmit buffers available in the core.
- `tx_cfg_req` in 1: the core requests the TX port for a configuration TLP.
- `tx_cfg_gnt` out 1: grant to the core for its configuration TLP.
- `r0_tdata`/`r1_tdata` in 32: requester data.
- `r0_tkeep`/`r1_tkeep` in 4: requester byte enables.
- `r0_tuser`/`r1_tuser` in 4: requester sideband.
- `r0_tlast`/`r1_tlast`, `r0_tvalid`/`r1_tvalid` in 1: requester last-beat and valid.
- `r0_tready`/`r1_tready` out 1: requester ready.
- `s_axis_tx_tdata` out 32, `s_axis_tx_tkeep` out 4, `s_axis_tx_tuser` out 4, `s_axis_tx_tlast` out 1, `s_axis_tx_tvalid` out 1: stream to the bridge.
- `s_axis_tx_tready` in 1: bridge ready.
- `grant` out 2: one-hot current owner (bit0 = r0, bit1 = r1). Value 0 when idle or in CFG.
- `busy` out 1: state is not IDLE.
- `r0_pkt_count`/`r1_pkt_count` out 16: packets completed per requester. Present only with `PCIE_TX_ARB_STATS_EN`.

## Operation
- State machine states: IDLE, GNT0, GNT1, CFG. All state is registered.
- Eligibility for a new requester grant: `user_lnk_up` = 1 and `tx_buf_av` ≥ `MIN_BUF_AV`.
- IDLE transitions, in priority order:
  - `tx_cfg_req` = 1 → CFG.
  - Otherwise, if eligible and exactly one `rN_tvalid` is high → GNTN.
  - If both are high → grant the requester that was not served last. A `last_served` register is reset to 1, so r0 wins the first tie.
- GNTN:
  - `s_axis_tx_t*` = `rN_t*`.
  - `rN_tready` = `s_axis_tx_tready`; the other requester's `tready` = 0.
  - A beat transfers when `rN_tvalid` and `s_axis_tx_tready` are both high.
  - A beat with `rN_tlast` = 1 → next state IDLE; `last_served` ← N; the matching packet counter increments.
- CFG: `tx_cfg_gnt` = 1 while `tx_cfg_req` = 1. Next state is IDLE on the first cycle `tx_cfg_req` is sampled low.
- IDLE outputs: `s_axis_tx_tvalid` = 0, `s_axis_tx_tlast` = 0, both `rN_tready` = 0. Data/keep/user outputs are 0.
- Boundary conditions:
  - `tx_cfg_req` rising mid-packet is held off until the packet's `tlast` beat.
  - `user_lnk_up` falling or `tx_buf_av` dropping mid-packet does not abort the packet; these are checked only in IDLE.
  - A requester deasserting `tvalid` mid-packet keeps the grant, and `s_axis_tx_tvalid` follows it.
  - `rst` in any state → IDLE next edge. An in-flight packet is truncated with no synthesized `tlast`. Packet counters and `last_served` are reset.
  - Packet counters wrap from 0xFFFF to 0x0000.

## Timing
- Reset values: `tx_cfg_gnt` = 0, `grant` = 0, `busy` = 0, all `s_axis_tx_*` = 0, `rN_tready` = 0, counters = 0.
- Grant latency: `rN_tvalid` sampled high in IDLE → `grant`/`rN_tready` high the next cycle.
- Data path latency: 0 cycles (combinational mux under the registered grant).
- Inter-packet gap: at least 1 IDLE cycle after each `tlast` beat.
- CFG latency: `tx_cfg_req` sampled in IDLE → `tx_cfg_gnt` high the next cycle. `tx_cfg_req` low → `tx_cfg_gnt` low the next cycle.
- Counters update on the edge that completes the `tlast` beat.

## Configuration
- `PCIE_TX_ARB_STATS_EN` defined:
  - 16-bit per-requester packet counters are present and driven on `r0_pkt_count`/`r1_pkt_count`.
- `PCIE_TX_ARB_STATS_EN` undefined:
  - The counter ports and registers are omitted entirely.
  - Arbitration behaviour is identical.

## Test plan
- Single packet: r0 sends a 4-beat packet (0x1..0x4, `tlast` on beat 4), bridge ready constant. → `grant` = 01 one cycle after `tvalid`; the bridge sees 4 beats with identical data; IDLE follows; `r0_pkt_count` = 1.
- Round robin: r0 and r1 both continuously valid with 2-beat packets, 6 packets total. → Grant order r0,r1,r0,r1,r0,r1; each count = 3.
- Backpressure: `s_axis_tx_tready` toggled every cycle during an 8-beat r1 packet. → Exactly 8 transfers, no duplicate or lost beats, `r1_tready` mirrors the bridge `tready`.
- Config preemption: `tx_cfg_req` raised on beat 2 of a 4-beat r0 packet while r1 is also valid. → r0 completes; CFG next; `tx_cfg_gnt` = 1 until `tx_cfg_req` drops; only then is r1 granted.
- Gating: `tx_buf_av` = 1 with `MIN_BUF_AV` = 2, r0 valid. → No grant. Raise `tx_buf_av` to 2 → grant the next cycle. With `user_lnk_up` = 0 → no grant.
- Reset mid-packet: `rst` asserted on beat 3 of a 5-beat r0 packet. → Next cycle: IDLE, all outputs 0, counters 0. After `rst` drops with both requesters valid, r0 is granted first.
